// File: rtl/instr_encoder.sv
// Encodes a decoded control bundle plus operand fields back into a 16-bit instruction word.
// Words are queued in a small output FIFO. Illegal bundles raise err and are counted.
module instr_encoder #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 16,
  parameter logic [3:0]  JUMP_OP = 4'd14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      ctrl,
  input  logic [3:0]       alu_fn,
  input  logic [3:0]       rs,
  input  logic [3:0]       rt,
  input  logic [3:0]       rd_imm,
  input  logic [11:0]      target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] instr_count,
  output logic [7:0]       err_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          ready_en;
  logic          legal;
  logic [15:0]   word;
  logic          accept, push, pop;

  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (ctrl)
      11'b01111000100: begin legal = 1'b1; word = {4'd0, rs, rt, rd_imm}; end
      11'b01000100100: begin legal = 1'b1; word = {4'd1, rs, rt, rd_imm}; end
      11'b10010000000: begin
        legal = (alu_fn <= 4'd9);
        word  = {4'd2 + alu_fn, rs, rt, rd_imm};
      end
      11'b00000010010: begin legal = 1'b1; word = {4'd12, rs, rt, rd_imm}; end
      11'b00000001010: begin legal = 1'b1; word = {4'd13, rs, rt, rd_imm}; end
      11'b00000000001: begin legal = 1'b1; word = {JUMP_OP, target}; end
      default: ;
    endcase
  end

  // ready_en keeps in_ready low for the reset cycle itself; in_ready never depends on out_ready.
  assign in_ready  = ready_en && (count < (PW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign instr     = out_valid ? mem[rd_ptr] : '0;

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err         <= 1'b0;
      instr_count <= '0;
      err_count   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      err   <= accept && !legal;
      if (push) instr_count <= instr_count + CNT_W'(1);
      if (accept && !legal && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed steps then random traffic, checked every cycle
// against a queue-based reference model of the encoder.
module tb_instr_encoder;
  localparam int DEPTH = 2;
  localparam logic [10:0] C_LW  = 11'b01111000100;
  localparam logic [10:0] C_SW  = 11'b01000100100;
  localparam logic [10:0] C_CAL = 11'b10010000000;
  localparam logic [10:0] C_BEQ = 11'b00000010010;
  localparam logic [10:0] C_BNE = 11'b00000001010;
  localparam logic [10:0] C_J   = 11'b00000000001;
  localparam logic [10:0] C_BAD = 11'b11111111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] ctrl = '0;
  logic [3:0]  alu_fn = '0, rs = '0, rt = '0, rd_imm = '0;
  logic [11:0] target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] instr;
  logic        err;
  logic [15:0] instr_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(16), .JUMP_OP(4'd14)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .alu_fn(alu_fn), .rs(rs), .rt(rt), .rd_imm(rd_imm),
    .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err), .instr_count(instr_count), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;
  int unsigned q[$];
  int unsigned m_icount = 0, m_ecount = 0;
  bit m_err = 0, m_ready_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_encode(input int c, input int fn, input int s, input int t,
                                     input int d, input int tg,
                                     output bit legal, output int unsigned w);
    int op;
    op = -1;
    if (c == int'(C_LW)) op = 0;
    else if (c == int'(C_SW)) op = 1;
    else if (c == int'(C_CAL) && fn <= 9) op = 2 + fn;
    else if (c == int'(C_BEQ)) op = 12;
    else if (c == int'(C_BNE)) op = 13;
    else if (c == int'(C_J)) begin
      legal = 1; w = 14 * 4096 + tg;
      return;
    end
    legal = (op >= 0);
    w = legal ? op * 4096 + s * 256 + t * 16 + d : 0;
  endfunction

  task automatic cycle();
    bit legal, acc, pop;
    int unsigned w;
    ref_encode(ctrl, alu_fn, rs, rt, rd_imm, target, legal, w);
    acc = in_valid && m_ready_en && q.size() < DEPTH;
    pop = q.size() > 0 && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_icount = 0; m_ecount = 0; m_err = 0; m_ready_en = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && legal) begin
        q.push_back(w);
        m_icount = (m_icount + 1) % 65536;
      end
      m_err = acc && !legal;
      if (m_err && m_ecount < 255) m_ecount++;
      m_ready_en = 1;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("instr", 32'(instr), q.size() > 0 ? q[0] : 0);
    chk("in_ready", 32'(in_ready), 32'(m_ready_en && q.size() < DEPTH));
    chk("err", 32'(err), 32'(m_err));
    chk("instr_count", 32'(instr_count), m_icount);
    chk("err_count", 32'(err_count), m_ecount);
  endtask

  task automatic req(input logic [10:0] c, input logic [3:0] fn, input logic [3:0] s,
                     input logic [3:0] t, input logic [3:0] d, input logic [11:0] tg);
    in_valid = 1'b1; ctrl = c; alu_fn = fn; rs = s; rt = t; rd_imm = d; target = tg;
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    cycle(); cycle();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    cycle();
    chk("ready_after_rst", 32'(in_ready), 1);

    // lw
    out_ready = 1'b1;
    req(C_LW, 4'd0, 4'd1, 4'd2, 4'd3, 12'h000);
    cycle();
    in_valid = 1'b0;
    chk("lw_word", 32'(instr), 32'h0123);
    chk("lw_valid", 32'(out_valid), 1);
    chk("lw_count", 32'(instr_count), 1);
    cycle();

    // cal, beq, jump back-to-back
    req(C_CAL, 4'd3, 4'd4, 4'd5, 4'd6, 12'h000);
    cycle();
    chk("cal_word", 32'(instr), 32'h5456);
    req(C_BEQ, 4'd0, 4'd1, 4'd2, 4'hF, 12'h000);
    cycle();
    chk("beq_word", 32'(instr), 32'hC12F);
    req(C_J, 4'd0, 4'd0, 4'd0, 4'd0, 12'hABC);
    cycle();
    chk("jump_word", 32'(instr), 32'hEABC);
    in_valid = 1'b0;
    cycle();

    // illegal bundles
    req(C_BAD, 4'd0, 4'd1, 4'd2, 4'd3, 12'h123);
    cycle();
    in_valid = 1'b0;
    chk("bad_err", 32'(err), 1);
    chk("bad_novalid", 32'(out_valid), 0);
    cycle();
    req(C_CAL, 4'd10, 4'd1, 4'd2, 4'd3, 12'h000);
    cycle();
    in_valid = 1'b0;
    chk("alufn_err", 32'(err), 1);
    cycle();
    chk("err_count_2", 32'(err_count), 2);
    chk("icount_4", 32'(instr_count), 4);

    // backpressure
    out_ready = 1'b0;
    req(C_BNE, 4'd0, 4'd7, 4'd8, 4'd9, 12'h000);
    cycle();
    req(C_SW, 4'd0, 4'd3, 4'd4, 4'd5, 12'h000);
    cycle();
    chk("full_not_ready", 32'(in_ready), 0);
    req(C_CAL, 4'd9, 4'd1, 4'd1, 4'd1, 12'h000);
    cycle(); cycle();
    chk("bp_hold", 32'(instr), 32'hD789);
    out_ready = 1'b1;
    cycle();
    chk("bp_second", 32'(instr), 32'h1345);
    cycle();
    in_valid = 1'b0;
    chk("bp_third", 32'(instr), 32'hB111);
    cycle(); cycle();

    // reset mid-stream
    out_ready = 1'b0;
    req(C_LW, 4'd0, 4'd9, 4'd9, 4'd9, 12'h000);
    cycle(); cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_icount", 32'(instr_count), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();

    // err_count saturation
    req(C_BAD, 4'd0, 4'd0, 4'd0, 4'd0, 12'h000);
    repeat (260) cycle();
    in_valid = 1'b0;
    chk("sat_count", 32'(err_count), 255);
    chk("sat_err_pulse", 32'(err), 1);
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 7);
      case (k)
        0: ctrl = C_LW;
        1: ctrl = C_SW;
        2: ctrl = C_CAL;
        3: ctrl = C_BEQ;
        4: ctrl = C_BNE;
        5: ctrl = C_J;
        6: ctrl = 11'($urandom);
        default: ctrl = C_CAL;
      endcase
      alu_fn    = (k == 7) ? 4'($urandom) : 4'($urandom_range(0, 9));
      rs        = 4'($urandom);
      rt        = 4'($urandom);
      rd_imm    = 4'($urandom);
      target    = 12'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
